// File: rtl/uart_fetch_controller.sv
// rtl/uart_fetch_controller.sv - UART instruction-fetch sequencer with single-entry reuse.
// Optional response timeout/retry under `UART_FETCH_TIMEOUT_EN.
module uart_fetch_controller #(
  parameter int          DIV_RATIO  = 163,
  parameter int          QUERY_HOLD = 2*DIV_RATIO+2
`ifdef UART_FETCH_TIMEOUT_EN
  ,
  parameter int          TIMEOUT    = 1_000_000,
  parameter int          MAX_RETRY  = 3,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  input  logic        flush,
  input  logic [31:0] uart_instr,
  input  logic        uart_word_end,
  output logic        instr_query,
  output logic [31:0] query_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        fetch_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUERY = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t      state, state_next;
  logic        we_d;
  logic [15:0] hold_cnt;
  logic [31:0] last_addr;
  logic        last_valid;

  logic word_rise;
  logic hit;
  logic hold_done;

  // uart_word_end is a slow level; only a fresh rising edge marks a new word
  assign word_rise = uart_word_end & ~we_d;
  assign hit       = last_valid & (fetch_addr == last_addr) & ~flush;
  assign hold_done = (hold_cnt == 16'(QUERY_HOLD - 1));

`ifdef UART_FETCH_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic [7:0]  retry_cnt;
  logic        timeout_hit;
  assign timeout_hit = (wait_cnt == 32'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      we_d       <= 1'b0;
      hold_cnt   <= 16'd0;
      query_addr <= 32'd0;
      instr      <= 32'd0;
      last_addr  <= 32'd0;
      last_valid <= 1'b0;
`ifdef UART_FETCH_TIMEOUT_EN
      wait_cnt   <= 32'd0;
      retry_cnt  <= 8'd0;
`endif
    end else begin
      state <= state_next;
      we_d  <= uart_word_end;
      if (flush) last_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fetch_req) begin
            hold_cnt <= 16'd0;
            if (!hit) query_addr <= fetch_addr;
`ifdef UART_FETCH_TIMEOUT_EN
            retry_cnt <= 8'd0;
`endif
          end
        end
        S_QUERY: begin
          hold_cnt <= hold_done ? 16'd0 : hold_cnt + 16'd1;
`ifdef UART_FETCH_TIMEOUT_EN
          wait_cnt <= 32'd0;
`endif
        end
        S_WAIT: begin
          // A completing fetch reloads the entry even if flushed meanwhile
          if (word_rise) begin
            instr      <= uart_instr;
            last_addr  <= query_addr;
            last_valid <= 1'b1;
          end
`ifdef UART_FETCH_TIMEOUT_EN
          else if (timeout_hit) begin
            wait_cnt <= 32'd0;
            if (retry_cnt < 8'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + 8'd1;
            end else begin
              instr      <= NOP_INSTR;
              last_valid <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next  = state;
    instr_query = 1'b0;
    instr_valid = 1'b0;
    stall       = 1'b0;
    fetch_error = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_req) state_next = hit ? S_DONE : S_QUERY;
      end
      S_QUERY: begin
        instr_query = 1'b1;
        stall       = 1'b1;
        if (hold_done) state_next = S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (word_rise) state_next = S_DONE;
`ifdef UART_FETCH_TIMEOUT_EN
        else if (timeout_hit)
          state_next = (retry_cnt < 8'(MAX_RETRY)) ? S_QUERY : S_ERROR;
`endif
      end
      S_DONE: begin
        instr_valid = 1'b1;
        state_next  = S_IDLE;
      end
      S_ERROR: begin
`ifdef UART_FETCH_TIMEOUT_EN
        instr_valid = 1'b1;
        fetch_error = 1'b1;
`endif
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_fetch_controller.sv
// tb/tb_uart_fetch_controller.sv - directed table-driven bench for uart_fetch_controller.
module tb_uart_fetch_controller;

  localparam int QUERY_HOLD = 2*163+2;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        flush;
  logic [31:0] uart_instr;
  logic        uart_word_end;
  logic        instr_query;
  logic [31:0] query_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        fetch_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_fetch_controller #(
    .DIV_RATIO(163)
`ifdef UART_FETCH_TIMEOUT_EN
    , .TIMEOUT(100), .MAX_RETRY(3)
`endif
  ) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .flush(flush), .uart_instr(uart_instr), .uart_word_end(uart_word_end),
    .instr_query(instr_query), .query_addr(query_addr), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .fetch_error(fetch_error)
  );

  // fmode: 0 none, 1 flush the cycle before the request, 2 flush with the request
  typedef struct {
    logic [31:0] addr;
    int          fmode;
    logic        pre_high;
    logic        miss;
    logic [31:0] resp;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_instr_query"}, 32'(instr_query), 32'd0);
    check({tag, "_query_addr"},  query_addr,        32'd0);
    check({tag, "_instr"},       instr,             32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid),  32'd0);
    check({tag, "_stall"},       32'(stall),        32'd0);
    check({tag, "_fetch_error"}, 32'(fetch_error),  32'd0);
  endtask

  task automatic do_fetch(input vec_t v);
    int n;
    int stall_low;
    int early_valid;
    if (v.fmode == 1) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
    end
    fetch_addr = v.addr;
    fetch_req  = 1'b1;
    flush      = (v.fmode == 2);
    if (v.pre_high) uart_word_end = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    flush     = 1'b0;
    if (!v.miss) begin
      check("hit_query", 32'(instr_query), 32'd0);
    end else begin
      check("query_addr", query_addr, v.addr);
      n = 0;
      stall_low = 0;
      while (instr_query && n < 2000) begin
        if (!stall) stall_low++;
        n++;
        @(negedge clk);
      end
      check("query_hold", 32'(n), 32'(QUERY_HOLD));
      early_valid = 0;
      for (int i = 0; i < 500; i++) begin
        if (!stall) stall_low++;
        if (instr_valid || instr_query) early_valid++;
        @(negedge clk);
      end
      check("wait_quiet", 32'(early_valid), 32'd0);
      if (v.pre_high) begin
        uart_word_end = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_high_no_done", 32'(stall), 32'd1);
      end
      uart_instr    = v.resp;
      uart_word_end = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!instr_valid && n < 20);
      check("resp_latency", 32'(n), 32'd1);
      check("stall_held", 32'(stall_low), 32'd0);
    end
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("instr", instr, v.exp_instr);
    check("done_stall", 32'(stall), 32'd0);
    check("no_error", 32'(fetch_error), 32'd0);
    @(negedge clk);
    uart_word_end = 1'b0;
    check("valid_pulse", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    int n;
    int queries;
    logic prev_q;

    vecs[0] = '{addr: 32'h40, fmode: 0, pre_high: 1'b0, miss: 1'b1, resp: 32'h00500093, exp_instr: 32'h00500093};
    vecs[1] = '{addr: 32'h40, fmode: 0, pre_high: 1'b0, miss: 1'b0, resp: 32'h0,        exp_instr: 32'h00500093};
    vecs[2] = '{addr: 32'h40, fmode: 1, pre_high: 1'b0, miss: 1'b1, resp: 32'h00100113, exp_instr: 32'h00100113};
    vecs[3] = '{addr: 32'h80, fmode: 0, pre_high: 1'b1, miss: 1'b1, resp: 32'hDEADBEEF, exp_instr: 32'hDEADBEEF};
    vecs[4] = '{addr: 32'h80, fmode: 0, pre_high: 1'b0, miss: 1'b0, resp: 32'h0,        exp_instr: 32'hDEADBEEF};
    vecs[5] = '{addr: 32'h40, fmode: 0, pre_high: 1'b0, miss: 1'b1, resp: 32'h12345678, exp_instr: 32'h12345678};
    vecs[6] = '{addr: 32'h40, fmode: 2, pre_high: 1'b0, miss: 1'b1, resp: 32'hCAFEF00D, exp_instr: 32'hCAFEF00D};

    reset = 1'b1; fetch_req = 1'b0; fetch_addr = 32'd0; flush = 1'b0;
    uart_instr = 32'd0; uart_word_end = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("reset");

    for (int i = 0; i < 7; i++) do_fetch(vecs[i]);

    // Reset while waiting for the response
    fetch_addr = 32'h100;
    fetch_req  = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    n = 0;
    while (instr_query && n < 2000) begin
      n++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("pre_reset_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("midreset");
    do_fetch(vecs[0]);

`ifdef UART_FETCH_TIMEOUT_EN
    fetch_addr = 32'h200;
    fetch_req  = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    queries = 1;
    prev_q  = instr_query;
    n = 0;
    while (!instr_valid && n < 5000) begin
      @(negedge clk);
      if (instr_query && !prev_q) queries++;
      prev_q = instr_query;
      n++;
    end
    check("to_queries", 32'(queries), 32'd4);
    check("to_valid", 32'(instr_valid), 32'd1);
    check("to_error", 32'(fetch_error), 32'd1);
    check("to_instr", instr, 32'h00000013);
    check("to_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("to_error_pulse", 32'(fetch_error), 32'd0);
    check("to_valid_pulse", 32'(instr_valid), 32'd0);
    check("to_idle_query", 32'(instr_query), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
